rot_seq: RTL and testbench
==========================

ROT_SEQ -- requirements
Module: rot_seq

Interface
REQ-001 Parameter NREG, default 8, number of piece registers in the register file.
REQ-002 Parameter AW, default 3, register address width; NREG SHALL equal 2**AW.
REQ-003 Parameters OP_RL_90, OP_UD_90, OP_FB_90, OP_RL_270, OP_UD_270, OP_FB_270, defaults 4'd8..4'd13; ALU opcodes, overridden at instantiation with the shared def.h encodings.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_rot  input  3  rotation select: 0 RL_90, 1 UD_90, 2 FB_90, 3 RL_270, 4 UD_270, 5 FB_270; 6 and 7 illegal.
REQ-009 cmd_base  input  AW  first piece register address.
REQ-010 cmd_cnt  input  AW+1  number of pieces to rotate, 0..NREG.
REQ-011 rd_addr  output  AW  register-file read address; rd_data valid combinationally.
REQ-012 rd_data  input  8  piece word: [7:3] piece id, [2:0] orientation.
REQ-013 alu_op, alu_in0, alu_in1  output  4, 8, 8  ALU operands; alu_in1 SHALL be 0.
REQ-014 alu_out  input  8  ALU result, combinational.
REQ-015 wr_en, wr_addr, wr_data  output  1, AW, 8  register-file write port.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse at command completion.
REQ-018 err  output  1  sticky error flag, cleared on next command accept.

Function
REQ-019 FSM states: IDLE, READ, EXEC, WRITE, FIN.
REQ-020 cmd_ready SHALL equal (state==IDLE); accept = cmd_valid & cmd_ready.
REQ-021 On accept, the block SHALL latch cmd_base to ptr, cmd_cnt to remaining, map cmd_rot to op_q, clear err, and go to READ; if cmd_cnt==0 go to FIN.
REQ-022 Illegal cmd_rot (6, 7) on accept SHALL set err, perform no writes, and go to FIN.
REQ-023 READ: drive rd_addr=ptr, latch rd_data into data_q; go to EXEC.
REQ-024 EXEC: drive alu_op=op_q, alu_in0=data_q, latch alu_out into res_q; go to WRITE.
REQ-025 If data_q[2:0] is 3'b110 or 3'b111 in EXEC, the block SHALL set err and flag the piece skipped.
REQ-026 WRITE: assert wr_en=1, wr_addr=ptr, wr_data=res_q for exactly one cycle unless skipped; decrement remaining, ptr=ptr+1 modulo NREG (wraps NREG-1 to 0).
REQ-027 After WRITE, go to READ if remaining!=0, else FIN.
REQ-028 FIN: pulse done for one cycle; go to IDLE.
REQ-029 Latency SHALL be 3*cmd_cnt+2 cycles from the accept edge to the done pulse; 2 cycles when cmd_cnt is 0 or the op is illegal.
REQ-030 cmd_valid while busy SHALL be ignored and not queued.
REQ-031 Outside EXEC, alu_op SHALL be held at OP_RL_90 and alu_in0 at 0; wr_en SHALL be 0 outside WRITE.
REQ-032 cmd_cnt > NREG SHALL be clamped to NREG.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, cmd_ready=1, busy=0, done=0, err=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, and all internal registers to 0.
REQ-034 Reset mid-command SHALL abort the command with no further writes and no done pulse.

Verification
REQ-035 reg[2]=8'b00001_000, cmd_rot=0, base=2, cnt=1 -> one write reg[2]=8'b00001_010, done at cycle 5, err=0.
REQ-036 regs 6,7,0 = orientations 000,001,101, cmd_rot=1, base=6, cnt=3 -> writes 001,101,011 to regs 6,7,0 (wrap), done at cycle 11.
REQ-037 reg[0] orientation 3'b111, cmd_rot=2, cnt=1 -> no wr_en, err=1, done pulses; the next accept clears err.
REQ-038 cmd_rot=6 or cnt=0 -> no writes, done at cycle 2, err=1 only for cmd_rot=6.
REQ-039 cmd_valid held high through a 2-piece command -> the second command is accepted only after IDLE returns; no overlap of wr_en.
REQ-040 rst_n low during EXEC of piece 2 of 4 -> outputs at reset values asynchronously, no done pulse, pieces 2..4 unchanged.

Source files
------------

// File: rtl/rot_seq.sv
// Piece-rotation sequencer: reads a run of piece registers, rotates each one through an external
// ALU and writes the result back, one piece every three cycles.
module rot_seq #(
  parameter int unsigned NREG      = 8,
  parameter int unsigned AW        = 3,
  parameter logic [3:0]  OP_RL_90  = 4'd8,
  parameter logic [3:0]  OP_UD_90  = 4'd9,
  parameter logic [3:0]  OP_FB_90  = 4'd10,
  parameter logic [3:0]  OP_RL_270 = 4'd11,
  parameter logic [3:0]  OP_UD_270 = 4'd12,
  parameter logic [3:0]  OP_FB_270 = 4'd13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_rot,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_cnt,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [3:0]    alu_op,
  output logic [7:0]    alu_in0,
  output logic [7:0]    alu_in1,
  input  logic [7:0]    alu_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWrite, StFin} state_t;

  localparam logic [AW:0] NregW = (AW + 1)'(NREG);

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;
  logic [3:0]    op_q;
  logic [7:0]    data_q;
  logic [7:0]    res_q;
  logic          skip_q;
  logic          done_q;
  logic          err_q;

  logic          accept;
  logic [AW:0]   cnt_clamped;
  logic [3:0]    op_map;
  logic          rot_illegal;

  assign accept      = cmd_valid && (state == StIdle);
  assign cnt_clamped = (cmd_cnt > NregW) ? NregW : cmd_cnt;

  always_comb begin
    op_map      = OP_RL_90;
    rot_illegal = 1'b0;
    case (cmd_rot)
      3'd0:    op_map = OP_RL_90;
      3'd1:    op_map = OP_UD_90;
      3'd2:    op_map = OP_FB_90;
      3'd3:    op_map = OP_RL_270;
      3'd4:    op_map = OP_UD_270;
      3'd5:    op_map = OP_FB_270;
      default: rot_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      ptr       <= '0;
      remaining <= '0;
      op_q      <= '0;
      data_q    <= '0;
      res_q     <= '0;
      skip_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        StIdle: begin
          if (accept) begin
            ptr       <= cmd_base;
            remaining <= cnt_clamped;
            op_q      <= op_map;
            err_q     <= rot_illegal;
            if (rot_illegal || (cnt_clamped == '0)) state <= StFin;
            else                                    state <= StRead;
          end
        end
        StRead: begin
          data_q <= rd_data;
          skip_q <= 1'b0;
          state  <= StExec;
        end
        StExec: begin
          res_q <= alu_out;
          // Orientation codes 6 and 7 are not valid; leave such a piece untouched.
          if (data_q[2:1] == 2'b11) begin
            skip_q <= 1'b1;
            err_q  <= 1'b1;
          end
          state <= StWrite;
        end
        StWrite: begin
          remaining <= remaining - 1'b1;
          ptr       <= ptr + 1'b1;
          state     <= (remaining != 1) ? StRead : StFin;
        end
        StFin: begin
          done_q <= 1'b1;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state == StIdle);
  assign busy      = (state != StIdle);
  assign done      = done_q;
  assign err       = err_q;
  assign rd_addr   = ptr;
  assign alu_op    = (state == StExec) ? op_q : OP_RL_90;
  assign alu_in0   = (state == StExec) ? data_q : 8'd0;
  assign alu_in1   = 8'd0;
  assign wr_en     = (state == StWrite) && !skip_q;
  assign wr_addr   = (state == StWrite) ? ptr : '0;
  assign wr_data   = (state == StWrite) ? res_q : 8'd0;

endmodule

// File: tb/tb_rot_seq.sv
// Directed bench for rot_seq with a behavioural register file and rotation ALU.
module tb_rot_seq;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_rot = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_cnt = '0;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [3:0]    alu_op;
  logic [7:0]    alu_in0, alu_in1, alu_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] regs [8];
  logic [7:0] ld_vals [8];
  logic       ld_all = 1'b0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  rot_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rot(cmd_rot), .cmd_base(cmd_base), .cmd_cnt(cmd_cnt),
    .rd_addr(rd_addr), .rd_data(rd_data), .alu_op(alu_op), .alu_in0(alu_in0),
    .alu_in1(alu_in1), .alu_out(alu_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] d);
    logic [2:0] o, r;
    o = d[2:0];
    case (op)
      4'd8:    r = 3'((int'(o) + 2) % 6);
      4'd9:    case (o)
                 3'd0: r = 3'd1;
                 3'd1: r = 3'd5;
                 3'd5: r = 3'd3;
                 3'd3: r = 3'd0;
                 default: r = o;
               endcase
      4'd10:   r = 3'((int'(o) + 1) % 6);
      4'd12:   r = 3'((int'(o) + 4) % 6);
      default: r = o;
    endcase
    return {d[7:3], r};
  endfunction

  assign alu_out = alu_f(alu_op, alu_in0);
  assign rd_data = regs[rd_addr];

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 8; i++) regs[i] <= ld_vals[i];
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic preload();
    @(negedge clk);
    ld_all = 1'b1;
    @(negedge clk);
    ld_all = 1'b0;
  endtask

  // Issue one command; cyc is the done cycle with the accept edge as cycle 1, -1 on timeout.
  task automatic run_cmd(input logic [2:0] rot, input logic [AW-1:0] base, input logic [AW:0] cnt,
                         output int cyc, output int nwr);
    int w0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rot = rot; cmd_base = base; cmd_cnt = cnt;
    w0 = wr_cnt;
    @(posedge clk);
    cyc = 1;
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) break;
      @(posedge clk);
      cyc++;
      #1;
    end
    if (done !== 1'b1) cyc = -1;
    nwr = wr_cnt - w0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({cmd_ready, busy, done, err, wr_en} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got %b want 10000", {cmd_ready, busy, done, err, wr_en});
    end
    checks++;
    if ({rd_addr, wr_addr, wr_data, alu_op, alu_in0, alu_in1} !== {3'd0, 3'd0, 8'd0, 4'd8, 8'd0, 8'd0}) begin
      errors++; $display("FAIL reset_data got %h", {rd_addr, wr_addr, wr_data, alu_op, alu_in0, alu_in1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int cyc, nwr;
    for (int i = 0; i < 8; i++) ld_vals[i] = {5'(i + 16), 3'b000};
    ld_vals[2] = 8'b00001_000;
    preload();
    run_cmd(3'd0, 3'd2, 4'd1, cyc, nwr);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL single_lat got %0d want 5", cyc); end
    checks++;
    if (nwr !== 1) begin errors++; $display("FAIL single_nwr got %0d want 1", nwr); end
    checks++;
    if (regs[2] !== 8'b00001_010) begin errors++; $display("FAIL single_val got %b want 00001010", regs[2]); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
  endtask

  task automatic test_wrap();
    int cyc, nwr;
    for (int i = 0; i < 8; i++) ld_vals[i] = 8'h00;
    ld_vals[6] = 8'b00010_000;
    ld_vals[7] = 8'b00011_001;
    ld_vals[0] = 8'b00100_101;
    ld_vals[1] = 8'b00101_000;
    preload();
    run_cmd(3'd1, 3'd6, 4'd3, cyc, nwr);
    checks++;
    if (cyc !== 11) begin errors++; $display("FAIL wrap_lat got %0d want 11", cyc); end
    checks++;
    if (nwr !== 3) begin errors++; $display("FAIL wrap_nwr got %0d want 3", nwr); end
    checks++;
    if ({regs[6], regs[7], regs[0], regs[1]} !== {8'b00010_001, 8'b00011_101, 8'b00100_011, 8'b00101_000}) begin
      errors++; $display("FAIL wrap_val got %h want 11 1d 23 28", {regs[6], regs[7], regs[0], regs[1]});
    end
  endtask

  task automatic test_bad_orient();
    int cyc, nwr;
    for (int i = 0; i < 8; i++) ld_vals[i] = 8'h00;
    ld_vals[0] = 8'b00011_111;
    preload();
    run_cmd(3'd2, 3'd0, 4'd1, cyc, nwr);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL orient_lat got %0d want 5", cyc); end
    checks++;
    if (nwr !== 0 || regs[0] !== 8'b00011_111) begin
      errors++; $display("FAIL orient_nowr got %0d/%b want 0/00011111", nwr, regs[0]);
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL orient_err got %b want 1", err); end
    run_cmd(3'd0, 3'd0, 4'd0, cyc, nwr);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
  endtask

  task automatic test_no_work();
    int cyc, nwr;
    run_cmd(3'd6, 3'd1, 4'd3, cyc, nwr);
    checks++;
    if (cyc !== 2 || nwr !== 0) begin errors++; $display("FAIL illegal_rot got %0d/%0d want 2/0", cyc, nwr); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", err); end
    run_cmd(3'd1, 3'd1, 4'd0, cyc, nwr);
    checks++;
    if (cyc !== 2 || nwr !== 0) begin errors++; $display("FAIL zero_cnt got %0d/%0d want 2/0", cyc, nwr); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL zero_err got %b want 0", err); end
  endtask

  task automatic test_clamp();
    int cyc, nwr;
    for (int i = 0; i < 8; i++) ld_vals[i] = {5'(i + 1), 3'b000};
    preload();
    run_cmd(3'd4, 3'd3, 4'd15, cyc, nwr);
    checks++;
    if (cyc !== 26 || nwr !== 8) begin errors++; $display("FAIL clamp got %0d/%0d want 26/8", cyc, nwr); end
    checks++;
    if (regs[0] !== 8'b00001_100 || regs[7] !== 8'b01000_100) begin
      errors++; $display("FAIL clamp_val got %b %b want 00001100 01000100", regs[0], regs[7]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, w0, a0;
    bit overlap;
    for (int i = 0; i < 8; i++) ld_vals[i] = 8'h00;
    ld_vals[4] = 8'b00101_000;
    ld_vals[5] = 8'b00110_000;
    preload();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rot = 3'd0; cmd_base = 3'd4; cmd_cnt = 4'd2;
    w0 = wr_cnt; a0 = acc_cnt; cyc = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); cyc++; #1;
      if (wr_en && cmd_ready) overlap = 1;
      if (done) break;
    end
    checks++;
    if (cyc !== 8 || acc_cnt - a0 !== 1) begin
      errors++; $display("FAIL b2b_first got %0d/%0d want 8/1", cyc, acc_cnt - a0);
    end
    @(posedge clk); #1;
    checks++;
    if (acc_cnt - a0 !== 2 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %0d/%b want 2/1", acc_cnt - a0, busy);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (wr_en && cmd_ready) overlap = 1;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1 || wr_cnt - w0 !== 4 || overlap) begin
      errors++; $display("FAIL b2b_writes got done=%b n=%0d ov=%0d want 1/4/0", done, wr_cnt - w0, overlap);
    end
    checks++;
    if (regs[4] !== 8'b00101_100 || regs[5] !== 8'b00110_100) begin
      errors++; $display("FAIL b2b_val got %b %b want 00101100 00110100", regs[4], regs[5]);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    for (int i = 0; i < 8; i++) ld_vals[i] = {5'(i + 8), 3'b000};
    preload();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rot = 3'd0; cmd_base = 3'd0; cmd_cnt = 4'd4;
    w0 = wr_cnt;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (alu_in0 !== 8'b01001_000) begin errors++; $display("FAIL mid_exec got %h want 48", alu_in0); end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, wr_en, rd_addr, wr_addr, wr_data} !== {5'b10000, 3'd0, 3'd0, 8'd0}) begin
      errors++; $display("FAIL mid_reset got %h", {cmd_ready, busy, done, err, wr_en, rd_addr, wr_addr, wr_data});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || wr_cnt - w0 !== 1) begin
      errors++; $display("FAIL mid_abort got done=%0d wr=%0d want 0/1", done_cnt - d0, wr_cnt - w0);
    end
    checks++;
    if ({regs[0], regs[1], regs[2], regs[3]} !== {8'b01000_010, 8'b01001_000, 8'b01010_000, 8'b01011_000}) begin
      errors++; $display("FAIL mid_regs got %h want 42 48 50 58", {regs[0], regs[1], regs[2], regs[3]});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_bad_orient();
    test_no_work();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
